smvm_result_collector: RTL and testbench
========================================

SMVM_RESULT_COLLECTOR -- requirements
Module: smvm_result_collector

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MAX_SHAPE, 512, maximum result rows
- SHAPE_BIT, 9, row-index width
- DATA_W, 13, result word width (matches the upstream SMVM data_out)

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle job-start pulse
- rows_in  input  SHAPE_BIT  number of result rows for the job; sampled with start
- in_valid  input  1  upstream SMVM out_valid
- data_in  input  DATA_W  upstream SMVM data_out
- out_valid  output  1  drain word available
- out_ready  input  1  downstream accepts the drain word
- out_data  output  DATA_W  result word
- out_idx  output  SHAPE_BIT  row index of out_data
- out_last  output  1  out_data is the final row
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse at job end
- err  output  1  sticky stray/overflow flag
- checksum  output  SHAPE_BIT+DATA_W  unsigned sum of all collected words

Function
REQ-003 The block SHALL implement the states IDLE, COLLECT and DRAIN.
REQ-004 IDLE: on start with rows_in>0, the block SHALL latch rows, clear wr_ptr, rd_ptr and checksum, and go to COLLECT next cycle.
REQ-005 IDLE: on start with rows_in==0, the block SHALL stay in IDLE and pulse done in the next cycle.
REQ-006 COLLECT: each in_valid cycle SHALL write data_in to mem[wr_ptr], increment wr_ptr and add data_in (zero-extended) to checksum.
REQ-007 COLLECT: the write with wr_ptr==rows-1 SHALL move the state to DRAIN on the same edge.
REQ-008 In COLLECT, in_valid SHALL be accepted on consecutive cycles with no bubble; gaps of any length SHALL be tolerated.
REQ-009 DRAIN: out_valid SHALL be 1.
- out_data = mem[rd_ptr]; out_idx = rd_ptr; out_last = (rd_ptr==rows-1).
- The first drain word SHALL appear in the first cycle after the final write (latency 1).
REQ-010 A handshake (out_valid && out_ready) SHALL advance rd_ptr by 1 the next cycle, allowing full throughput of one word per cycle.
REQ-011 While out_ready==0, out_data, out_idx and out_last SHALL hold stable.
REQ-012 A handshake on out_last SHALL return the state to IDLE and pulse done in the next cycle; out_valid SHALL be 0 in that cycle.
REQ-013 in_valid while in IDLE or DRAIN SHALL drop the word, leave mem and checksum unchanged, and set err.
- This includes in_valid in the same cycle as start.
REQ-014 start while busy SHALL be ignored and SHALL NOT set err.
REQ-015 err SHALL clear only on reset or on an accepted start.
REQ-016 checksum SHALL be SHAPE_BIT+DATA_W bits wide, never overflow for rows<=MAX_SHAPE, and hold its value after done until the next accepted start.
REQ-017 rows_in values above MAX_SHAPE are not representable and need no handling.

Reset
REQ-018 On rst_n low, asynchronously:
- state=IDLE
- all pointers, rows and checksum = 0
- out_valid, out_last, busy, done, err = 0
- out_data and out_idx = 0
REQ-019 Reset mid-COLLECT or mid-DRAIN SHALL abandon the job; mem contents need not be cleared.

Structure
REQ-020 MAX_SHAPE, SHAPE_BIT, DATA_W and the state encoding SHALL live in the shared package smvm_pkg.
REQ-021 The result storage SHALL be a sub-module smvm_result_ram: MAX_SHAPE x DATA_W, one synchronous write port and one combinational read port, no reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Basic job: start rows_in=4, in_valid words 10,20,30,40 back-to-back, out_ready=1 -> out_data 10,20,30,40 with out_idx 0..3, out_last on idx 3, checksum=100, then done pulse.
- Backpressure: rows_in=3, out_ready low for 5 cycles at idx 1 -> idx 1 word held stable; order and values intact; no loss.
- Stray input: in_valid in IDLE with data 0x1FFF -> err=1, checksum 0; next accepted start clears err.
- Zero-row job: start rows_in=0 -> done pulse one cycle later, busy stays 0.
- Max job: rows_in=511, all words 0x1FFF -> checksum=511*8191=4185601; all 511 words drained in order.
- Reset mid-DRAIN: assert rst_n low at idx 2 of 4 -> all outputs 0 immediately; a new job then runs correctly.

Source files
------------

// File: rtl/smvm_pkg.sv
// Shared sizes and state encoding for the SMVM result path.
// Imported by the collector, its interface and its RAM.
package smvm_pkg;

  localparam int MAX_SHAPE = 512;
  localparam int SHAPE_BIT = 9;
  localparam int DATA_W    = 13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } col_state_t;

endpackage

// File: rtl/smvm_result_collector_if.sv
// Streaming bundle around the collector: SMVM result input
// and the valid/ready drain output.
interface smvm_result_collector_if #(
  parameter int SHAPE_BIT = smvm_pkg::SHAPE_BIT,
  parameter int DATA_W    = smvm_pkg::DATA_W
);

  logic                 in_valid;
  logic [DATA_W-1:0]    data_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [SHAPE_BIT-1:0] out_idx;
  logic                 out_last;

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_idx,
    output out_last
  );

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last
  );

endinterface

// File: rtl/smvm_result_ram.sv
// Result storage: one synchronous write port and one
// combinational read port, contents are not reset.
module smvm_result_ram #(
  parameter int DEPTH = smvm_pkg::MAX_SHAPE,
  parameter int AW    = smvm_pkg::SHAPE_BIT,
  parameter int DW    = smvm_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/smvm_result_collector.sv
// Buffers one job of SMVM result rows, then drains them in
// order on a valid/ready stream with a running checksum.
module smvm_result_collector #(
  parameter int MAX_SHAPE = smvm_pkg::MAX_SHAPE,
  parameter int SHAPE_BIT = smvm_pkg::SHAPE_BIT,
  parameter int DATA_W    = smvm_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SHAPE_BIT-1:0]  rows_in,
  smvm_result_collector_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SHAPE_BIT+DATA_W-1:0] checksum
);

  import smvm_pkg::*;

  localparam int CSUM_W = SHAPE_BIT + DATA_W;

  col_state_t r_state, w_state_nxt;

  logic [SHAPE_BIT-1:0] r_rows, w_rows_nxt;
  logic [SHAPE_BIT-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [SHAPE_BIT-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [CSUM_W-1:0]    r_csum, w_csum_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;

  logic                 w_we;
  logic [DATA_W-1:0]    w_rdata;
  logic                 w_wr_last;
  logic                 w_rd_last;
  logic                 w_drain;

  assign w_drain   = (r_state == ST_DRAIN);
  assign w_wr_last = (r_wr_ptr == r_rows - SHAPE_BIT'(1));
  assign w_rd_last = (r_rd_ptr == r_rows - SHAPE_BIT'(1));

  smvm_result_ram #(
    .DEPTH (MAX_SHAPE),
    .AW    (SHAPE_BIT),
    .DW    (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // next-state, pointer, checksum and flag logic
  always_comb begin
    w_state_nxt  = r_state;
    w_rows_nxt   = r_rows;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_csum_nxt   = r_csum;
    w_err_nxt    = r_err;
    w_done_nxt   = 1'b0;
    w_we         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_err_nxt = 1'b0;
          if (rows_in != '0) begin
            w_rows_nxt   = rows_in;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_csum_nxt   = '0;
            w_state_nxt  = ST_COLLECT;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
        // a stray word wins over the err clear of start
        if (bus.in_valid) w_err_nxt = 1'b1;
      end
      ST_COLLECT: begin
        if (bus.in_valid) begin
          w_we         = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + SHAPE_BIT'(1);
          w_csum_nxt   = r_csum + CSUM_W'(bus.data_in);
          if (w_wr_last) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.in_valid) w_err_nxt = 1'b1;
        if (bus.out_ready) begin
          if (w_rd_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_rd_ptr_nxt = r_rd_ptr + SHAPE_BIT'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rows   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_csum   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rows   <= w_rows_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_csum   <= w_csum_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // drain outputs are forced to zero outside DRAIN so the
  // unreset RAM never leaks onto the bus
  assign bus.out_valid = w_drain;
  assign bus.out_data  = w_drain ? w_rdata : '0;
  assign bus.out_idx   = w_drain ? r_rd_ptr : '0;
  assign bus.out_last  = w_drain & w_rd_last;

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign checksum = r_csum;

endmodule

// File: tb/tb_smvm_result_collector.sv
// Directed bench for smvm_result_collector with a queue
// scoreboard checked on every drain cycle.
module tb_smvm_result_collector;

  localparam int SB = 9;
  localparam int DW = 13;

  typedef struct {
    logic [DW-1:0] d;
    logic [SB-1:0] i;
    logic          l;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [SB-1:0] rows_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [SB+DW-1:0] checksum;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  smvm_result_collector_if #(.SHAPE_BIT(SB), .DATA_W(DW)) bus();

  smvm_result_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rows_in  (rows_in),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int rows);
    start   = 1'b1;
    rows_in = SB'(rows);
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input int w, input int idx, input int rows);
    exp_t e;
    e.d = DW'(w);
    e.i = SB'(idx);
    e.l = (idx == rows - 1);
    q.push_back(e);
    bus.in_valid = 1'b1;
    bus.data_in  = DW'(w);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_vld_at_done"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_sb_drained"}, 64'(q.size()), 64'd0);
  endtask

  // scoreboard monitor: every shown drain word must match the
  // queue head; a handshake retires it
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_word", 64'd1, 64'd0);
      end else begin
        chk("sb_data", 64'(bus.out_data), 64'(q[0].d));
        chk("sb_idx",  64'(bus.out_idx),  64'(q[0].i));
        chk("sb_last", 64'(bus.out_last), 64'(q[0].l));
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    rows_in       = '0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_busy",     64'(busy),          64'd0);
    chk("rst_done",     64'(done),          64'd0);
    chk("rst_err",      64'(err),           64'd0);
    chk("rst_csum",     64'(checksum),      64'd0);
    chk("rst_vld",      64'(bus.out_valid), 64'd0);
    chk("rst_data",     64'(bus.out_data),  64'd0);
    chk("rst_idx",      64'(bus.out_idx),   64'd0);
    chk("rst_last",     64'(bus.out_last),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // stray input in IDLE
    bus.in_valid = 1'b1;
    bus.data_in  = 13'h1FFF;
    tick();
    bus.in_valid = 1'b0;
    chk("stray_err",  64'(err),      64'd1);
    chk("stray_csum", 64'(checksum), 64'd0);
    chk("stray_busy", 64'(busy),     64'd0);

    // basic job, start clears err
    start_job(4);
    chk("basic_err_clr", 64'(err),  64'd0);
    chk("basic_busy",    64'(busy), 64'd1);
    send(10, 0, 4);
    send(20, 1, 4);
    send(30, 2, 4);
    send(40, 3, 4);
    chk("basic_lat1_vld", 64'(bus.out_valid), 64'd1);
    chk("basic_lat1_idx", 64'(bus.out_idx),   64'd0);
    wait_done(20, "basic");
    chk("basic_csum", 64'(checksum), 64'd100);
    tick();
    chk("basic_done_pulse", 64'(done),     64'd0);
    chk("basic_csum_hold",  64'(checksum), 64'd100);

    // backpressure, gap and ignored start while busy
    start_job(3);
    send(7, 0, 3);
    start   = 1'b1;
    rows_in = SB'(9);
    tick();
    start = 1'b0;
    chk("busy_start_err", 64'(err), 64'd0);
    send(8, 1, 3);
    tick();
    send(9, 2, 3);
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_idx_hold",  64'(bus.out_idx),  64'd1);
      chk("bp_data_hold", 64'(bus.out_data), 64'd8);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_done(20, "bp");
    chk("bp_csum", 64'(checksum), 64'd24);
    chk("bp_err",  64'(err),      64'd0);

    // zero-row job
    tick();
    start_job(0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    tick();
    chk("zero_done_pulse", 64'(done), 64'd0);
    chk("zero_busy2",      64'(busy), 64'd0);

    // max job
    start_job(511);
    for (int k = 0; k < 511; k++) send(13'h1FFF, k, 511);
    wait_done(1000, "max");
    chk("max_csum", 64'(checksum), 64'd4185601);

    // reset mid-DRAIN
    tick();
    start_job(4);
    send(1, 0, 4);
    send(2, 1, 4);
    send(3, 2, 4);
    send(4, 3, 4);
    tick();
    tick();
    chk("mid_idx_pre", 64'(bus.out_idx), 64'd2);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_vld",  64'(bus.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.out_data),  64'd0);
    chk("mid_rst_idx",  64'(bus.out_idx),   64'd0);
    chk("mid_rst_last", 64'(bus.out_last),  64'd0);
    chk("mid_rst_busy", 64'(busy),          64'd0);
    chk("mid_rst_csum", 64'(checksum),      64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_job(2);
    send(5, 0, 2);
    send(6, 1, 2);
    wait_done(20, "post_rst");
    chk("post_rst_csum", 64'(checksum), 64'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
